// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch handshake for the RISC-V core: redirect and
// wrong-path drop handling, one-entry output register backed by a one-entry skid buffer.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flag,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush,
    output logic        misalign
);

    localparam logic [1:0]  ST_BOOT = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_HALT = 2'd2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    function automatic logic [31:0] half_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFE;
    endfunction

    logic [1:0]  state_r;
    logic        pend_r;
    logic        req_r;
    logic        drop_r;
    logic [31:0] addr_r;
    logic [31:0] tgt_r;
    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_pc_r;
    logic        sk_valid_r;
    logic [31:0] sk_instr_r;
    logic [31:0] sk_pc_r;
    logic        misalign_r;

    logic        live_s;
    logic        take_s;
    logic        mis_s;
    logic        redir_s;
    logic        accept_s;
    logic        good_s;
    logic        out_free_s;
    logic        issue_s;
    logic [1:0]  state_n_s;
    logic        pend_base_s;
    logic        pend_n_s;
    logic        req_n_s;
    logic        drop_n_s;
    logic [31:0] addr_n_s;
    logic [31:0] tgt_n_s;
    logic        out_valid_n_s;
    logic [31:0] out_instr_n_s;
    logic [31:0] out_pc_n_s;
    logic        sk_valid_n_s;
    logic [31:0] sk_instr_n_s;
    logic [31:0] sk_pc_n_s;

    // Per-cycle qualifiers: a taken flag is only honoured outside HALT.
    always_comb begin
        live_s     = (state_r != ST_HALT);
        take_s     = flag && live_s;
        mis_s      = take_s && target[1];
        redir_s    = take_s && !target[1];
        accept_s   = pend_r && imem_ready;
        good_s     = accept_s && !drop_r && (state_r == ST_REQ);
        out_free_s = !out_valid_r || !stall;
    end

    // Sequencer state: a misaligned target parks the fetch unit until reset.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_BOOT: state_n_s = mis_s ? ST_HALT : ST_REQ;
            ST_REQ:  state_n_s = mis_s ? ST_HALT : ST_REQ;
            ST_HALT: state_n_s = ST_HALT;
            default: state_n_s = ST_HALT;
        endcase
    end

    // Output register and skid buffer; a waiting skid entry always drains first.
    always_comb begin
        out_valid_n_s = out_valid_r;
        out_instr_n_s = out_instr_r;
        out_pc_n_s    = out_pc_r;
        sk_valid_n_s  = sk_valid_r;
        sk_instr_n_s  = sk_instr_r;
        sk_pc_n_s     = sk_pc_r;
        if (take_s || !live_s) begin
            out_valid_n_s = 1'b0;
            sk_valid_n_s  = 1'b0;
        end else if (out_free_s) begin
            if (sk_valid_r) begin
                out_valid_n_s = 1'b1;
                out_instr_n_s = sk_instr_r;
                out_pc_n_s    = sk_pc_r;
                sk_valid_n_s  = good_s;
                if (good_s) begin
                    sk_instr_n_s = imem_rdata;
                    sk_pc_n_s    = addr_r;
                end else begin
                    sk_instr_n_s = sk_instr_r;
                    sk_pc_n_s    = sk_pc_r;
                end
            end else if (good_s) begin
                out_valid_n_s = 1'b1;
                out_instr_n_s = imem_rdata;
                out_pc_n_s    = addr_r;
            end else begin
                out_valid_n_s = 1'b0;
            end
        end else if (good_s) begin
            sk_valid_n_s = 1'b1;
            sk_instr_n_s = imem_rdata;
            sk_pc_n_s    = addr_r;
        end else begin
            sk_valid_n_s = sk_valid_r;
        end
    end

    // Fetch address and request control; an in-flight request keeps its address until it completes.
    always_comb begin
        pend_base_s = pend_r;
        drop_n_s    = drop_r;
        addr_n_s    = addr_r;
        tgt_n_s     = tgt_r;
        if (redir_s && pend_r && !imem_ready) begin
            drop_n_s    = 1'b1;
            tgt_n_s     = half_align(target);
            pend_base_s = 1'b1;
        end else if (redir_s) begin
            drop_n_s    = 1'b0;
            addr_n_s    = half_align(target);
            pend_base_s = 1'b0;
        end else if (accept_s) begin
            drop_n_s    = 1'b0;
            pend_base_s = 1'b0;
            addr_n_s    = drop_r ? tgt_r : (addr_r + 32'd4);
        end else begin
            pend_base_s = pend_r;
        end
        issue_s  = (state_n_s == ST_REQ) && !pend_base_s && !sk_valid_n_s;
        pend_n_s = pend_base_s || issue_s;
        req_n_s  = pend_n_s && (state_n_s == ST_REQ);
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            pend_r      <= 1'b0;
            req_r       <= 1'b0;
            drop_r      <= 1'b0;
            addr_r      <= RESET_PC;
            tgt_r       <= RESET_PC;
            out_valid_r <= 1'b0;
            out_instr_r <= NOP;
            out_pc_r    <= RESET_PC;
            sk_valid_r  <= 1'b0;
            sk_instr_r  <= NOP;
            sk_pc_r     <= RESET_PC;
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            pend_r      <= pend_n_s;
            req_r       <= req_n_s;
            drop_r      <= drop_n_s;
            addr_r      <= addr_n_s;
            tgt_r       <= tgt_n_s;
            out_valid_r <= out_valid_n_s;
            out_instr_r <= out_instr_n_s;
            out_pc_r    <= out_pc_n_s;
            sk_valid_r  <= sk_valid_n_s;
            sk_instr_r  <= sk_instr_n_s;
            sk_pc_r     <= sk_pc_n_s;
            misalign_r  <= mis_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign if_valid  = out_valid_r;
    assign if_instr  = out_instr_r;
    assign if_pc     = out_pc_r;
    assign flush     = take_s;
    assign misalign  = misalign_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: cycle table for streaming/wait states,
// hand sequences for redirect, stall, flag+stall and misalignment, plus a delivery scoreboard.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flag = 1'b0;
    logic [31:0] target = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        misalign;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flag(flag), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .misalign(misalign)
    );

    typedef struct {
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    int          completions = 0;
    bit          wrongpath = 1'b0;
    bit          halted = 1'b0;

    function automatic vec_t mkv(input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, memory returns its own address as data.
    task automatic step(input logic st, input logic fl, input logic [31:0] tg, input logic rdy);
        logic [31:0] exp_pc;
        @(negedge clk);
        stall = st; flag = fl; target = tg; imem_ready = rdy; imem_rdata = imem_addr;
        #1;
        if (if_valid && !st && !fl) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: got pc %h expected none at %0t", if_pc, $time);
            end else begin
                exp_pc = sb.pop_front();
                chk32("sb_pc", if_pc, exp_pc);
                chk32("sb_instr", if_instr, exp_pc);
            end
        end
        if (fl) sb.delete();
        if (imem_req && rdy) begin
            completions++;
            if (!fl && !wrongpath && !halted) sb.push_back(imem_addr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; flag = 1'b0; target = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, 32'h0000_0000);
        chk1("rst_valid", if_valid, 1'b0);
        chk32("rst_instr", if_instr, 32'h0000_0013);
        chk32("rst_pc", if_pc, 32'h0000_0000);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        sb.delete(); wrongpath = 1'b0; halted = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);
        chk32("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // c0 BOOT with a stray ready, c1..c4 zero-wait, then ready every third cycle.
        tbl[0]  = mkv(1'b1, 1'b0, 32'd0,  1'b0, 32'd0);
        tbl[1]  = mkv(1'b1, 1'b1, 32'd0,  1'b0, 32'd0);
        tbl[2]  = mkv(1'b1, 1'b1, 32'd4,  1'b1, 32'd0);
        tbl[3]  = mkv(1'b1, 1'b1, 32'd8,  1'b1, 32'd4);
        tbl[4]  = mkv(1'b1, 1'b1, 32'd12, 1'b1, 32'd8);
        tbl[5]  = mkv(1'b0, 1'b1, 32'd16, 1'b1, 32'd12);
        tbl[6]  = mkv(1'b0, 1'b1, 32'd16, 1'b0, 32'd0);
        tbl[7]  = mkv(1'b1, 1'b1, 32'd16, 1'b0, 32'd0);
        tbl[8]  = mkv(1'b0, 1'b1, 32'd20, 1'b1, 32'd16);
        tbl[9]  = mkv(1'b0, 1'b1, 32'd20, 1'b0, 32'd0);
        tbl[10] = mkv(1'b1, 1'b1, 32'd20, 1'b0, 32'd0);
        tbl[11] = mkv(1'b0, 1'b1, 32'd24, 1'b1, 32'd20);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'd0, tbl[i].rdy);
            chk1("tbl_req", imem_req, tbl[i].e_req);
            chk32("tbl_addr", imem_addr, tbl[i].e_addr);
            chk1("tbl_valid", if_valid, tbl[i].e_valid);
            chk1("tbl_flush", flush, 1'b0);
            if (tbl[i].e_valid) begin
                chk32("tbl_pc", if_pc, tbl[i].e_pc);
                chk32("tbl_instr", if_instr, tbl[i].e_pc);
            end
        end
        drain();

        // Redirect to 0x100 while the 0x10 request waits three more cycles.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        chk1("redir_flush", flush, 1'b1);
        chk32("redir_addr_pend", imem_addr, 32'h0000_0010);
        wrongpath = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, (i == 2) ? 1'b1 : 1'b0);
            chk1("redir_req_held", imem_req, 1'b1);
            chk32("redir_addr_stable", imem_addr, 32'h0000_0010);
            chk1("redir_no_valid", if_valid, 1'b0);
            chk1("redir_flush_low", flush, 1'b0);
        end
        wrongpath = 1'b0;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk32("redir_new_addr", imem_addr, 32'h0000_0100);
        chk1("redir_valid_wait", if_valid, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("redir_valid", if_valid, 1'b1);
        chk32("redir_pc", if_pc, 32'h0000_0100);
        drain();

        // Stall held four cycles during zero-wait streaming.
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);
        completions = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            chk1("stall_valid", if_valid, 1'b1);
            chk32("stall_pc_frozen", if_pc, 32'd8);
        end
        chk32("stall_completions", 32'(completions), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk32("stall_release_pc", if_pc, 32'd8);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("stall_nogap_v1", if_valid, 1'b1);
        chk32("stall_nogap_pc1", if_pc, 32'd12);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("stall_nogap_v2", if_valid, 1'b1);
        chk32("stall_nogap_pc2", if_pc, 32'd16);
        drain();

        // Flag and stall together: redirect wins.
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        chk1("fs_flush", flush, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        chk1("fs_valid_low", if_valid, 1'b0);
        chk32("fs_addr", imem_addr, 32'h0000_0200);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("fs_valid", if_valid, 1'b1);
        chk32("fs_pc", if_pc, 32'h0000_0200);
        drain();

        // Misaligned target halts fetch until reset.
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        chk1("mis_flush", flush, 1'b1);
        chk1("mis_not_yet", misalign, 1'b0);
        halted = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("mis_pulse", misalign, 1'b1);
        chk1("mis_req_off", imem_req, 1'b0);
        chk1("mis_valid_off", if_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i == 1) ? 1'b1 : 1'b0, 32'h0000_0300, 1'b1);
            chk1("halt_misalign_low", misalign, 1'b0);
            chk1("halt_req", imem_req, 1'b0);
            chk1("halt_valid", if_valid, 1'b0);
            chk1("halt_flush", flush, 1'b0);
        end
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk1("post_halt_req", imem_req, 1'b1);
        chk32("post_halt_addr", imem_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
